data_checker: RTL and testbench

- Consumes the 256-bit AXI stream produced by the data generator after it returns over the QSFP link.
- Each beat carries 16 lanes of 16 bits; every lane must hold the same incrementing 16-bit counter value.
- Checks per-beat lane consistency and sequence continuity, then counts good beats and errors for the status/register layer.
- Always-ready sink; the generator stage is the producer feeding it.

---
 rtl/data_checker.sv | 204 ++++++++++++++++++++
 tb/tb_data_checker.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_checker.sv
// data_checker
//   Sink for the 256-bit counter stream returned over the QSFP link. Every
//   beat carries 16 lanes of 16 bits and all lanes should hold the same value,
//   which should increase by one from beat to beat (mod 2^16). The checker
//   first locks onto the stream in SYNC and then verifies continuity in CHECK.
//   It counts accepted beats and bad beats.
//
//   Optional build macro: DATACHK_CAPTURE_EN adds capture of the first bad beat.
//
// Ports
//   clock              sole clock, rising edge
//   resetn             synchronous active-low reset
//   clear              synchronous; zeroes counters, returns to SYNC, drops any
//                      beat offered in the same cycle
//   AXIS_TDATA[255:0]  stream data, lane k = bits [16k+15:16k]
//   AXIS_TVALID        beat valid
//   AXIS_TREADY        sink ready (low only while in reset)
//   beat_count         accepted beats since reset/clear (wraps)
//   error_count        bad beats since reset/clear (saturates)
//   error              sticky error flag since reset/clear
//   locked             high while in CHECK
//   first_bad_data     (DATACHK_CAPTURE_EN) TDATA of first bad beat
//   first_bad_expected (DATACHK_CAPTURE_EN) expected value at that beat
//   first_bad_beat     (DATACHK_CAPTURE_EN) beat_count at that beat
module data_checker #(
    parameter int ERR_WIDTH  = 32,
    parameter int BEAT_WIDTH = 48
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  clear,
    input  logic [255:0]          AXIS_TDATA,
    input  logic                  AXIS_TVALID,
    output logic                  AXIS_TREADY,
    output logic [BEAT_WIDTH-1:0] beat_count,
    output logic [ERR_WIDTH-1:0]  error_count,
    output logic                  error,
    output logic                  locked
`ifdef DATACHK_CAPTURE_EN
    ,
    output logic [255:0]          first_bad_data,
    output logic [15:0]           first_bad_expected,
    output logic [BEAT_WIDTH-1:0] first_bad_beat
`endif
);

    typedef enum logic [0:0] {
        SYNC  = 1'b0,
        CHECK = 1'b1
    } state_t;

    localparam logic [ERR_WIDTH-1:0]  ERR_MAX  = {ERR_WIDTH{1'b1}};
    localparam logic [ERR_WIDTH-1:0]  ERR_ONE  = {{(ERR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [BEAT_WIDTH-1:0] BEAT_ONE = {{(BEAT_WIDTH-1){1'b0}}, 1'b1};

    // True when lanes 0..14 all match lane 15.
    function automatic logic lanes_equal(input logic [255:0] data);
        logic eq;
        eq = 1'b1;
        for (int k = 0; k < 15; k++) begin
            eq = eq & (data[16*k +: 16] == data[255:240]);
        end
        return eq;
    endfunction

    state_t                  state_r, state_nxt_s;
    logic                    tready_r;
    logic [15:0]             expected_r, expected_nxt_s;
    logic [BEAT_WIDTH-1:0]   beat_r, beat_nxt_s;
    logic [ERR_WIDTH-1:0]    err_cnt_r, err_cnt_nxt_s;
    logic                    error_r, error_nxt_s;
    logic                    locked_r;
    logic                    accept_s;
    logic [15:0]             ref_s;
    logic                    consistent_s;
    logic                    good_s;
    logic                    bad_s;

    assign accept_s     = AXIS_TVALID & tready_r;
    assign ref_s        = AXIS_TDATA[255:240];
    assign consistent_s = lanes_equal(AXIS_TDATA);
    assign good_s       = consistent_s & (ref_s == expected_r);

    // Next-state, sequence tracking and counter updates.
    always_comb begin
        state_nxt_s    = state_r;
        expected_nxt_s = expected_r;
        beat_nxt_s     = beat_r;
        err_cnt_nxt_s  = err_cnt_r;
        error_nxt_s    = error_r;
        bad_s          = 1'b0;
        if (clear) begin
            // A beat offered alongside clear is discarded entirely.
            state_nxt_s    = SYNC;
            expected_nxt_s = 16'd0;
            beat_nxt_s     = {BEAT_WIDTH{1'b0}};
            err_cnt_nxt_s  = {ERR_WIDTH{1'b0}};
            error_nxt_s    = 1'b0;
        end else if (accept_s) begin
            beat_nxt_s = beat_r + BEAT_ONE;
            case (state_r)
                SYNC: begin
                    // Only lane consistency matters while acquiring lock.
                    if (consistent_s) begin
                        expected_nxt_s = ref_s + 16'd1;
                        state_nxt_s    = CHECK;
                    end else begin
                        bad_s = 1'b1;
                    end
                end
                CHECK: begin
                    if (good_s) begin
                        expected_nxt_s = expected_r + 16'd1;
                    end else begin
                        // Resync on lane 15 so one corrupt beat costs one count.
                        bad_s          = 1'b1;
                        expected_nxt_s = ref_s + 16'd1;
                    end
                end
                default: begin
                    state_nxt_s = SYNC;
                end
            endcase
            if (bad_s) begin
                error_nxt_s = 1'b1;
                if (err_cnt_r != ERR_MAX) begin
                    err_cnt_nxt_s = err_cnt_r + ERR_ONE;
                end else begin
                    err_cnt_nxt_s = err_cnt_r;
                end
            end else begin
                error_nxt_s = error_r;
            end
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_r    <= SYNC;
            tready_r   <= 1'b0;
            expected_r <= 16'd0;
            beat_r     <= {BEAT_WIDTH{1'b0}};
            err_cnt_r  <= {ERR_WIDTH{1'b0}};
            error_r    <= 1'b0;
            locked_r   <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            tready_r   <= 1'b1;
            expected_r <= expected_nxt_s;
            beat_r     <= beat_nxt_s;
            err_cnt_r  <= err_cnt_nxt_s;
            error_r    <= error_nxt_s;
            locked_r   <= (state_nxt_s == CHECK);
        end
    end

    assign AXIS_TREADY = tready_r;
    assign beat_count  = beat_r;
    assign error_count = err_cnt_r;
    assign error       = error_r;
    assign locked      = locked_r;

`ifdef DATACHK_CAPTURE_EN
    logic                  captured_r;
    logic [255:0]          cap_data_r;
    logic [15:0]           cap_exp_r;
    logic [BEAT_WIDTH-1:0] cap_beat_r;
    logic [15:0]           bad_exp_s;

    // Expected value for a bad beat: running expectation in CHECK, lane 15 in SYNC.
    always_comb begin
        if (state_r == CHECK) begin
            bad_exp_s = expected_r;
        end else begin
            bad_exp_s = ref_s;
        end
    end

    // First-bad-beat capture, held until reset or clear.
    always_ff @(posedge clock) begin
        if (!resetn || clear) begin
            captured_r <= 1'b0;
            cap_data_r <= 256'd0;
            cap_exp_r  <= 16'd0;
            cap_beat_r <= {BEAT_WIDTH{1'b0}};
        end else if (bad_s && !captured_r) begin
            captured_r <= 1'b1;
            cap_data_r <= AXIS_TDATA;
            cap_exp_r  <= bad_exp_s;
            cap_beat_r <= beat_r;
        end else begin
            captured_r <= captured_r;
        end
    end

    assign first_bad_data     = cap_data_r;
    assign first_bad_expected = cap_exp_r;
    assign first_bad_beat     = cap_beat_r;
`endif

endmodule

// File: tb/tb_data_checker.sv
// Scoreboard bench for data_checker: the driver updates a high-level model and
// queues the expected status after each event; a monitor pops and compares.
module tb_data_checker;
    localparam int EW = 8;
    localparam int BW = 48;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic          clear = 1'b0;
    logic [255:0]  tdata = 256'd0;
    logic          tvalid = 1'b0;
    logic          tready;
    logic [BW-1:0] beat_count;
    logic [EW-1:0] error_count;
    logic          error;
    logic          locked;
`ifdef DATACHK_CAPTURE_EN
    logic [255:0]  fb_data;
    logic [15:0]   fb_exp;
    logic [BW-1:0] fb_beat;
`endif

    always #5 clock = ~clock;

    data_checker #(.ERR_WIDTH(EW), .BEAT_WIDTH(BW)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .clear       (clear),
        .AXIS_TDATA  (tdata),
        .AXIS_TVALID (tvalid),
        .AXIS_TREADY (tready),
        .beat_count  (beat_count),
        .error_count (error_count),
        .error       (error),
        .locked      (locked)
`ifdef DATACHK_CAPTURE_EN
        ,
        .first_bad_data     (fb_data),
        .first_bad_expected (fb_exp),
        .first_bad_beat     (fb_beat)
`endif
    );

    typedef struct {
        longint unsigned beats;
        int unsigned     errs;
        bit              err;
        bit              lck;
        logic [255:0]    cdata;
        logic [15:0]     cexp;
        longint unsigned cbeat;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // reference model state
    bit              m_locked;
    logic [15:0]     m_exp;
    longint unsigned m_beats;
    int unsigned     m_errs;
    bit              m_err;
    bit              m_cap;
    logic [255:0]    m_cdata;
    logic [15:0]     m_cexp;
    longint unsigned m_cbeat;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic m_init();
        m_locked = 0; m_exp = 16'd0; m_beats = 0; m_errs = 0; m_err = 0;
        m_cap = 0; m_cdata = 256'd0; m_cexp = 16'd0; m_cbeat = 0;
    endtask

    function automatic logic [255:0] mk(input logic [15:0] v);
        logic [255:0] d;
        for (int k = 0; k < 16; k++) d[16*k +: 16] = v;
        return d;
    endfunction

    task automatic model(input logic [255:0] d, input bit v, input bit c);
        exp_t        e;
        logic [15:0] r;
        bit          cons;
        bit          bad;
        logic [15:0] bexp;
        if (c) begin
            m_init();
        end else if (v) begin
            r = d[255:240];
            cons = 1;
            for (int k = 0; k < 16; k++) if (d[16*k +: 16] != r) cons = 0;
            bad  = !cons || (m_locked && r != m_exp);
            bexp = m_locked ? m_exp : r;
            if (bad) begin
                m_err = 1;
                if (m_errs != (1 << EW) - 1) m_errs++;
                if (!m_cap) begin
                    m_cap = 1; m_cdata = d; m_cexp = bexp; m_cbeat = m_beats;
                end
            end
            if (cons || m_locked) begin
                m_exp    = r + 16'd1;
                m_locked = 1;
            end
            m_beats = (m_beats + 1) & 64'h0000_FFFF_FFFF_FFFF;
        end
        e.beats = m_beats; e.errs = m_errs; e.err = m_err; e.lck = m_locked;
        e.cdata = m_cdata; e.cexp = m_cexp; e.cbeat = m_cbeat;
        exp_q.push_back(e);
    endtask

    // drive one cycle of inputs; queue expectation when an event happens
    task automatic step(input logic [255:0] d, input bit v, input bit c);
        @(negedge clock);
        tdata = d; tvalid = v; clear = c;
        if (resetn && (v || c)) model(d, v, c);
    endtask

    task automatic send(input logic [15:0] v);
        step(mk(v), 1'b1, 1'b0);
    endtask

    task automatic idle();
        step(256'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input int n);
        @(negedge clock);
        resetn = 0; tvalid = 1; tdata = mk(16'h4444); clear = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            check("rst_tready", tready, 0);
            check("rst_beats", beat_count, 0);
            check("rst_errs", error_count, 0);
            check("rst_flags", {error, locked}, 0);
        end
        resetn = 1; tvalid = 0;
        m_init();
        @(negedge clock);
        check("tready_after_rst", tready, 1);
    endtask

    // monitor: compare DUT status after every clock edge that carried an event
    exp_t e_mon;
    bit   evt;
    always @(posedge clock) begin
        evt = resetn && (tvalid || clear);
        if (evt) begin
            #1;
            if (exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL sb_underflow: got empty queue, expected an entry");
            end else begin
                e_mon = exp_q.pop_front();
                check("sb_beats", beat_count, e_mon.beats);
                check("sb_errs", error_count, e_mon.errs);
                check("sb_error", error, e_mon.err);
                check("sb_locked", locked, e_mon.lck);
                check("sb_tready", tready, 1);
`ifdef DATACHK_CAPTURE_EN
                check("sb_cap_data", fb_data, e_mon.cdata);
                check("sb_cap_exp", fb_exp, e_mon.cexp);
                check("sb_cap_beat", fb_beat, e_mon.cbeat);
`endif
            end
        end
    end

    logic [255:0] bad_d;
    logic [15:0]  v;
    int           cnt;
    int           k;

    initial begin
        m_init();
        do_reset(3);

        // clean ramp
        for (int i = 0; i < 1000; i++) send(i[15:0]);
        idle();
        check("ramp_beats", beat_count, 1000);
        check("ramp_errs", error_count, 0);
        check("ramp_flags", {error, locked}, 2'b01);

        // single corrupted lane
        step(256'd0, 1'b0, 1'b1);
        send(16'h1234); send(16'h1235);
        bad_d = mk(16'h1236); bad_d[15:0] = 16'h1237;
        step(bad_d, 1'b1, 1'b0);
        send(16'h1237); send(16'h1238);
        idle();
        check("corrupt_errs", error_count, 1);
        check("corrupt_error", error, 1);
`ifdef DATACHK_CAPTURE_EN
        check("corrupt_cap_exp", fb_exp, 16'h1236);
        check("corrupt_cap_beat", fb_beat, 2);
        check("corrupt_cap_data", fb_data, bad_d);
`endif

        // wrap of the 16-bit counter
        step(256'd0, 1'b0, 1'b1);
        send(16'hFFFE); send(16'hFFFF); send(16'h0000); send(16'h0001);
        idle();
        check("wrap_beats", beat_count, 4);
        check("wrap_errs", error_count, 0);

        // sequence skip
        step(256'd0, 1'b0, 1'b1);
        send(16'h0010); send(16'h0011); send(16'h0020); send(16'h0021);
        idle();
        check("skip_errs", error_count, 1);

        // random valid gaps
        step(256'd0, 1'b0, 1'b1);
        v = 16'($urandom); cnt = 0;
        while (cnt < 500) begin
            if ($urandom_range(1, 0) == 1) begin
                send(v); v = v + 16'd1; cnt++;
            end else begin
                step(mk(16'($urandom)), 1'b0, 1'b0);
            end
        end
        idle();
        check("gaps_beats", beat_count, 500);
        check("gaps_errs", error_count, 0);

        // clear coincident with a beat, then resume elsewhere
        for (int i = 0; i < 8; i++) send(16'h0300 + i[15:0]);
        send(16'h0400);
        step(mk(16'h0309), 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) send(16'h7000 + i[15:0]);
        idle();
        check("clr_beats", beat_count, 10);
        check("clr_errs", error_count, 0);
        check("clr_flags", {error, locked}, 2'b01);

        // reset mid-stream, then resume elsewhere
        for (int i = 0; i < 8; i++) send(16'h0500 + i[15:0]);
        send(16'h0600);
        do_reset(2);
        for (int i = 0; i < 10; i++) send(16'h7000 + i[15:0]);
        idle();
        check("rst_mid_beats", beat_count, 10);
        check("rst_mid_errs", error_count, 0);
        check("rst_mid_flags", {error, locked}, 2'b01);

        // random corruption, jumps, gaps and occasional clear
        v = 16'($urandom);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(63, 0) == 0) begin
                step(mk(v), 1'b1, 1'b1);
            end else if ($urandom_range(3, 0) == 0) begin
                idle();
            end else begin
                if ($urandom_range(15, 0) == 0) v = 16'($urandom);
                bad_d = mk(v);
                if ($urandom_range(7, 0) == 0) begin
                    k = int'($urandom_range(15, 0));
                    bad_d[16*k +: 16] = bad_d[16*k +: 16] ^ 16'($urandom_range(65535, 1));
                end
                step(bad_d, 1'b1, 1'b0);
                v = v + 16'd1;
            end
        end

        // error counter saturation with an unlockable stream
        step(256'd0, 1'b0, 1'b1);
        for (int i = 0; i < 300; i++) begin
            bad_d = mk(i[15:0]);
            bad_d[31:16] = ~bad_d[31:16];
            step(bad_d, 1'b1, 1'b0);
        end
        idle();
        check("sat_errs", error_count, 8'hFF);
        check("sat_beats", beat_count, 300);
        check("sat_flags", {error, locked}, 2'b10);

        idle(); idle();
        check("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
